uart_clk_gen: RTL and testbench

UART_CLK_GEN -- requirements
Module: uart_clk_gen

---
 rtl/uart_clk_gen.sv | 110 +++++++++++
 tb/tb_uart_clk_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_clk_gen.sv
// Two independent UART bit-clock generators (tx, rx). Each produces a square
// wave of period 2*H clk cycles, starting low one cycle after its enable is seen.
module uart_clk_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] half_div,
  input  logic                 uart_enable_tx,
  input  logic                 uart_enable_rx,
  output logic                 clk_uart_tx,
  output logic                 clk_uart_rx,
  output logic                 busy_tx,
  output logic                 busy_rx,
  output logic                 div_err
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [1:0] enable;
  logic [1:0] start;
  logic [1:0] uart_clk;
  logic [1:0] busy;
  logic       div_zero;
  logic       div_err_reg;

  // Index 0 is the tx channel, index 1 the rx channel.
  assign enable   = {uart_enable_rx, uart_enable_tx};
  assign div_zero = (half_div == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      state_t               state_reg;
      logic [DIV_WIDTH-1:0] cnt_reg;
      logic [DIV_WIDTH-1:0] hl_reg;
      logic                 clk_reg;
      logic                 busy_reg;

      assign start[gi] = (state_reg == IDLE) && enable[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          hl_reg    <= ONE;
          clk_reg   <= 1'b1;
          busy_reg  <= 1'b0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (enable[gi]) begin
                state_reg <= LOW;
                clk_reg   <= 1'b0;
                busy_reg  <= 1'b1;
                cnt_reg   <= '0;
                hl_reg    <= div_zero ? ONE : half_div;
              end
            end
            LOW, HIGH: begin
              // A dropped enable wins over a phase toggle on the same cycle.
              if (!enable[gi]) begin
                state_reg <= IDLE;
                clk_reg   <= 1'b1;
                busy_reg  <= 1'b0;
                cnt_reg   <= '0;
              end else if (cnt_reg == hl_reg - ONE) begin
                cnt_reg   <= '0;
                state_reg <= (state_reg == LOW) ? HIGH : LOW;
                clk_reg   <= (state_reg == LOW);
              end else begin
                cnt_reg   <= cnt_reg + ONE;
              end
            end
            default: begin
              state_reg <= IDLE;
              clk_reg   <= 1'b1;
              busy_reg  <= 1'b0;
              cnt_reg   <= '0;
            end
          endcase
        end
      end

      assign uart_clk[gi] = clk_reg;
      assign busy[gi]     = busy_reg;
    end
  endgenerate

  // Both channels see the same half_div, so giving tx priority only matters
  // for which start is credited; the flag value is identical.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_err_reg <= 1'b0;
    end else if (start[0]) begin
      div_err_reg <= div_zero;
    end else if (start[1]) begin
      div_err_reg <= div_zero;
    end
  end

  assign clk_uart_tx = uart_clk[0];
  assign clk_uart_rx = uart_clk[1];
  assign busy_tx     = busy[0];
  assign busy_rx     = busy[1];
  assign div_err     = div_err_reg;

endmodule

// File: tb/tb_uart_clk_gen.sv
// Checks uart_clk_gen against a frame-time model: each channel's output is
// derived from cycles elapsed since its frame start and the frozen divisor.
module tb_uart_clk_gen;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] half_div = '0;
  logic          en_tx = 1'b0;
  logic          en_rx = 1'b0;
  logic          clk_uart_tx, clk_uart_rx, busy_tx, busy_rx, div_err;

  uart_clk_gen #(.DIV_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .half_div      (half_div),
    .uart_enable_tx(en_tx),
    .uart_enable_rx(en_rx),
    .clk_uart_tx   (clk_uart_tx),
    .clk_uart_rx   (clk_uart_rx),
    .busy_tx       (busy_tx),
    .busy_rx       (busy_rx),
    .div_err       (div_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: frame active flag, cycles since frame start, latched H.
  bit m_act [2];
  int m_t   [2];
  int m_h   [2];
  bit m_err;

  function automatic logic exp_clk(int c);
    if (!m_act[c]) return 1'b1;
    return ((m_t[c] / m_h[c]) % 2) == 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_act[c] = 1'b0;
      m_t[c]   = 0;
      m_h[c]   = 1;
    end
    m_err = 1'b0;
  endtask

  // Applies one rising edge using the inputs that were stable before it.
  task automatic model_update();
    bit en [2];
    bit st [2];
    if (!rst) begin
      model_reset();
      return;
    end
    en[0] = en_tx;
    en[1] = en_rx;
    for (int c = 0; c < 2; c++) st[c] = !m_act[c] && en[c];
    if (st[0] || st[1]) m_err = (half_div == 0);
    for (int c = 0; c < 2; c++) begin
      if (st[c]) begin
        m_act[c] = 1'b1;
        m_t[c]   = 0;
        m_h[c]   = (half_div == 0) ? 1 : int'(half_div);
      end else if (m_act[c] && !en[c]) begin
        m_act[c] = 1'b0;
      end else if (m_act[c]) begin
        m_t[c]++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("clk_uart_tx", clk_uart_tx, exp_clk(0));
    chk("clk_uart_rx", clk_uart_rx, exp_clk(1));
    chk("busy_tx", busy_tx, m_act[0]);
    chk("busy_rx", busy_rx, m_act[1]);
    chk("div_err", div_err, m_err);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_update();
      #1;
      check_all();
    end
  endtask

  initial begin
    model_reset();

    // Reset held with both enables high: outputs idle, no toggling.
    en_tx    = 1'b1;
    en_rx    = 1'b1;
    half_div = 16'd4;
    #2 rst = 1'b0;
    #1 check_all();
    step(2);
    #3 rst = 1'b1;
    step(3);

    // H=4 on tx only: 4 low, 4 high, repeating; rx stays high.
    en_rx = 1'b0;
    step(20);
    en_tx = 1'b0;
    step(2);

    // H=8 on rx, dropped 3 cycles into LOW.
    half_div = 16'd8;
    en_rx    = 1'b1;
    step(4);
    en_rx = 1'b0;
    step(4);

    // Zero divisor toggles every cycle and flags div_err; H=5 clears it.
    half_div = 16'd0;
    en_tx    = 1'b1;
    step(6);
    en_tx = 1'b0;
    step(1);
    half_div = 16'd5;
    en_tx    = 1'b1;
    step(12);
    en_tx = 1'b0;
    step(2);

    // Divisor frozen mid-frame; the next frame picks up the new value.
    half_div = 16'd6;
    en_tx    = 1'b1;
    step(4);
    half_div = 16'd2;
    step(20);
    en_tx = 1'b0;
    step(1);
    en_tx = 1'b1;
    step(10);
    en_tx = 1'b0;
    step(2);

    // Independent channels: tx H=3, rx H=10 seven cycles later, tx dropped.
    half_div = 16'd3;
    en_tx    = 1'b1;
    step(7);
    half_div = 16'd10;
    en_rx    = 1'b1;
    step(15);
    en_tx = 1'b0;
    step(25);
    en_rx = 1'b0;
    step(2);

    // Enable re-asserted right after the return to idle.
    half_div = 16'd2;
    en_tx    = 1'b1;
    step(5);
    en_tx = 1'b0;
    step(1);
    en_tx = 1'b1;
    step(6);

    // Asynchronous reset mid-frame with both channels running.
    en_rx = 1'b1;
    step(5);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    step(2);
    #2 rst = 1'b1;
    step(4);

    // Randomized enables and divisor changes.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) en_tx = ~en_tx;
      if ($urandom_range(15) == 0) en_rx = ~en_rx;
      if ($urandom_range(7) == 0) half_div = DW'($urandom_range(7));
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
